// File: rtl/flood_engine.sv
// flood_engine: game-state core for a flood-it style board.
//
// A board of SIZE x SIZE cells is streamed in raster order. Each cell holds a colour and an
// "owned" flag. Ownership grows from cell (0,0) by repeated raster passes (SWEEP) until a pass
// adds nothing. The owned region is then repainted with the target colour (PAINT). Player moves
// select a new target colour. The game is won once every cell is owned.
//
// Ports:
//   CLOCK, RESET_N          clock, asynchronous active-low reset
//   LOAD_START, SIZE,       start a board load; SIZE clamped to 2..MAX_SIZE,
//   COLOR_NUM               COLOR_NUM clamped to 3..8
//   LOAD_VALID, LOAD_COLOR  raster cell stream
//   MOVE_VALID, MOVE_COLOR  player move strobe and requested colour
//   RD_ROW, RD_COL          combinational display read address
//   RD_COLOR, RD_OWNED      cell contents at the read address (0 when out of range)
//   BUSY, BOARD_VALID,      status: loading/computing, board stable,
//   MOVE_REJECT, GAME_WON   one-cycle pulse on a rejected move, game won
//   MOVE_COUNT, OWNED_COUNT accepted moves since load, owned cells
module flood_engine #(
  parameter int unsigned MAX_SIZE = 26,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned MOVE_W   = 8
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               LOAD_START,
  input  logic [4:0]         SIZE,
  input  logic [3:0]         COLOR_NUM,
  input  logic               LOAD_VALID,
  input  logic [COLOR_W-1:0] LOAD_COLOR,
  input  logic               MOVE_VALID,
  input  logic [COLOR_W-1:0] MOVE_COLOR,
  input  logic [4:0]         RD_ROW,
  input  logic [4:0]         RD_COL,
  output logic [COLOR_W-1:0] RD_COLOR,
  output logic               RD_OWNED,
  output logic               BUSY,
  output logic               BOARD_VALID,
  output logic               MOVE_REJECT,
  output logic               GAME_WON,
  output logic [MOVE_W-1:0]  MOVE_COUNT,
  output logic [9:0]         OWNED_COUNT
);

  localparam logic [4:0] SizeMax = 5'(MAX_SIZE);

  typedef enum logic [2:0] {StIdle, StLoad, StSweep, StPaint, StReady, StWon} state_e;

  state_e               state_q, state_d;
  logic [4:0]           size_q, size_d;
  logic [3:0]           color_num_q, color_num_d;
  logic [4:0]           row_q, row_d;
  logic [4:0]           col_q, col_d;
  logic [COLOR_W-1:0]   target_q, target_d;
  logic                 changed_q, changed_d;
  logic [MOVE_W-1:0]    move_count_q, move_count_d;
  logic [9:0]           owned_count_q, owned_count_d;
  logic                 move_reject_q, move_reject_d;
  logic [COLOR_W-1:0]   color_q [MAX_SIZE][MAX_SIZE];
  logic [COLOR_W-1:0]   color_d [MAX_SIZE][MAX_SIZE];
  logic [MAX_SIZE-1:0]  owned_q [MAX_SIZE];
  logic [MAX_SIZE-1:0]  owned_d [MAX_SIZE];

  logic       last_col, last_cell;
  logic [9:0] size_sq;
  logic       nb_owned;
  logic       cell_new;

  assign last_col  = (col_q == size_q - 5'd1);
  assign last_cell = last_col && (row_q == size_q - 5'd1);
  assign size_sq   = 10'(size_q) * 10'(size_q);

  // Any in-bounds 4-neighbour of the scan cell already owned. Only meaningful while scanning,
  // where the pointer is always inside the board.
  always_comb begin
    nb_owned = 1'b0;
    if (state_q == StSweep) begin
      if (row_q != 5'd0)          nb_owned = nb_owned | owned_q[row_q - 5'd1][col_q];
      if (row_q + 5'd1 < size_q)  nb_owned = nb_owned | owned_q[row_q + 5'd1][col_q];
      if (col_q != 5'd0)          nb_owned = nb_owned | owned_q[row_q][col_q - 5'd1];
      if (col_q + 5'd1 < size_q)  nb_owned = nb_owned | owned_q[row_q][col_q + 5'd1];
    end
  end

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    color_num_d   = color_num_q;
    row_d         = row_q;
    col_d         = col_q;
    target_d      = target_q;
    changed_d     = changed_q;
    move_count_d  = move_count_q;
    owned_count_d = owned_count_q;
    move_reject_d = 1'b0;
    color_d       = color_q;
    owned_d       = owned_q;
    cell_new      = 1'b0;

    if (LOAD_START) begin
      if (SIZE < 5'd2)          size_d = 5'd2;
      else if (SIZE > SizeMax)  size_d = SizeMax;
      else                      size_d = SIZE;
      if (COLOR_NUM < 4'd3)       color_num_d = 4'd3;
      else if (COLOR_NUM > 4'd8)  color_num_d = 4'd8;
      else                        color_num_d = COLOR_NUM;
      owned_d       = '{default: '0};
      move_count_d  = '0;
      owned_count_d = '0;
      row_d         = '0;
      col_d         = '0;
      changed_d     = 1'b0;
      state_d       = StLoad;
    end else begin
      unique case (state_q)
        StLoad: begin
          // Pointer wraps past the last row once every cell has been written.
          if (row_q == size_q) begin
            owned_d[0][0] = 1'b1;
            owned_count_d = 10'd1;
            target_d      = color_q[0][0];
            row_d         = '0;
            col_d         = '0;
            changed_d     = 1'b0;
            state_d       = StSweep;
          end else if (LOAD_VALID) begin
            color_d[row_q][col_q] = LOAD_COLOR;
            if (last_col) begin
              col_d = '0;
              row_d = row_q + 5'd1;
            end else begin
              col_d = col_q + 5'd1;
            end
          end
        end
        StSweep: begin
          if (!owned_q[row_q][col_q] && (color_q[row_q][col_q] == target_q) && nb_owned) begin
            owned_d[row_q][col_q] = 1'b1;
            owned_count_d         = owned_count_q + 10'd1;
            changed_d             = 1'b1;
            cell_new              = 1'b1;
          end
          if (last_cell) begin
            row_d     = '0;
            col_d     = '0;
            changed_d = 1'b0;
            if (!(changed_q || cell_new)) state_d = StPaint;
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
        StPaint: begin
          if (owned_q[row_q][col_q]) color_d[row_q][col_q] = target_q;
          if (last_cell) begin
            row_d   = '0;
            col_d   = '0;
            state_d = (owned_count_q == size_sq) ? StWon : StReady;
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
        StReady: begin
          if (MOVE_VALID) begin
            if ((8'(MOVE_COLOR) >= 8'(color_num_q)) || (MOVE_COLOR == color_q[0][0])) begin
              move_reject_d = 1'b1;
            end else begin
              if (move_count_q != {MOVE_W{1'b1}}) begin
                move_count_d = move_count_q + {{(MOVE_W-1){1'b0}}, 1'b1};
              end
              target_d  = MOVE_COLOR;
              row_d     = '0;
              col_d     = '0;
              changed_d = 1'b0;
              state_d   = StSweep;
            end
          end
        end
        StIdle, StWon: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= StIdle;
      size_q        <= '0;
      color_num_q   <= '0;
      row_q         <= '0;
      col_q         <= '0;
      target_q      <= '0;
      changed_q     <= 1'b0;
      move_count_q  <= '0;
      owned_count_q <= '0;
      move_reject_q <= 1'b0;
      color_q       <= '{default: '0};
      owned_q       <= '{default: '0};
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      color_num_q   <= color_num_d;
      row_q         <= row_d;
      col_q         <= col_d;
      target_q      <= target_d;
      changed_q     <= changed_d;
      move_count_q  <= move_count_d;
      owned_count_q <= owned_count_d;
      move_reject_q <= move_reject_d;
      color_q       <= color_d;
      owned_q       <= owned_d;
    end
  end

  always_comb begin
    RD_COLOR = '0;
    RD_OWNED = 1'b0;
    if ((RD_ROW < size_q) && (RD_COL < size_q)) begin
      RD_COLOR = color_q[RD_ROW][RD_COL];
      RD_OWNED = owned_q[RD_ROW][RD_COL];
    end
  end

  assign BUSY        = (state_q == StLoad) || (state_q == StSweep) || (state_q == StPaint);
  assign BOARD_VALID = (state_q == StReady) || (state_q == StWon);
  assign GAME_WON    = (state_q == StWon);
  assign MOVE_REJECT = move_reject_q;
  assign MOVE_COUNT  = move_count_q;
  assign OWNED_COUNT = owned_count_q;

endmodule

// File: tb/tb_flood_engine.sv
module tb_flood_engine;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       LOAD_START = 1'b0;
  logic [4:0] SIZE = '0;
  logic [3:0] COLOR_NUM = '0;
  logic       LOAD_VALID = 1'b0;
  logic [2:0] LOAD_COLOR = '0;
  logic       MOVE_VALID = 1'b0;
  logic [2:0] MOVE_COLOR = '0;
  logic [4:0] RD_ROW = '0;
  logic [4:0] RD_COL = '0;
  logic [2:0] RD_COLOR;
  logic       RD_OWNED;
  logic       BUSY;
  logic       BOARD_VALID;
  logic       MOVE_REJECT;
  logic       GAME_WON;
  logic [7:0] MOVE_COUNT;
  logic [9:0] OWNED_COUNT;

  flood_engine dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .LOAD_START(LOAD_START), .SIZE(SIZE),
    .COLOR_NUM(COLOR_NUM), .LOAD_VALID(LOAD_VALID), .LOAD_COLOR(LOAD_COLOR),
    .MOVE_VALID(MOVE_VALID), .MOVE_COLOR(MOVE_COLOR), .RD_ROW(RD_ROW), .RD_COL(RD_COL),
    .RD_COLOR(RD_COLOR), .RD_OWNED(RD_OWNED), .BUSY(BUSY), .BOARD_VALID(BOARD_VALID),
    .MOVE_REJECT(MOVE_REJECT), .GAME_WON(GAME_WON), .MOVE_COUNT(MOVE_COUNT),
    .OWNED_COUNT(OWNED_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: board contents, owned set and counters.
  int m_size = 0;
  int m_cn = 0;
  int m_moves = 0;
  int m_owned = 0;
  int m_col [26][26];
  bit m_own [26][26];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Grow the owned region through cells of colour tgt (breadth-first), then repaint it.
  function automatic void m_flood(int tgt);
    int q[$];
    int dr[4] = '{-1, 1, 0, 0};
    int dc[4] = '{0, 0, -1, 1};
    int idx, r, c, nr, nc;
    for (int i = 0; i < m_size; i++)
      for (int j = 0; j < m_size; j++)
        if (m_own[i][j]) q.push_back(i * 32 + j);
    while (q.size() > 0) begin
      idx = q.pop_front();
      r = idx / 32;
      c = idx % 32;
      for (int k = 0; k < 4; k++) begin
        nr = r + dr[k];
        nc = c + dc[k];
        if (nr >= 0 && nr < m_size && nc >= 0 && nc < m_size) begin
          if (!m_own[nr][nc] && m_col[nr][nc] == tgt) begin
            m_own[nr][nc] = 1'b1;
            q.push_back(nr * 32 + nc);
          end
        end
      end
    end
    m_owned = 0;
    for (int i = 0; i < m_size; i++)
      for (int j = 0; j < m_size; j++)
        if (m_own[i][j]) begin
          m_col[i][j] = tgt;
          m_owned++;
        end
  endfunction

  function automatic void m_clear_own();
    for (int i = 0; i < 26; i++)
      for (int j = 0; j < 26; j++) m_own[i][j] = 1'b0;
    m_owned = 0;
    m_moves = 0;
  endfunction

  function automatic void m_new_board();
    m_clear_own();
    m_own[0][0] = 1'b1;
    m_flood(m_col[0][0]);
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic start_load(input int raw_size, input int raw_cn);
    LOAD_START = 1'b1;
    SIZE = 5'(raw_size);
    COLOR_NUM = 4'(raw_cn);
    tick();
    LOAD_START = 1'b0;
    m_size = clamp(raw_size, 2, 26);
    m_cn = clamp(raw_cn, 3, 8);
    m_clear_own();
  endtask

  task automatic stream(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          LOAD_VALID = 1'b0;
          LOAD_COLOR = 3'($urandom);
          tick();
        end
      end
      LOAD_VALID = 1'b1;
      LOAD_COLOR = 3'(m_col[i / m_size][i % m_size]);
      tick();
    end
    LOAD_VALID = 1'b0;
  endtask

  task automatic scan(input string tag);
    int bad = 0;
    int lim;
    int ec, eo;
    lim = ((m_size > 3) ? m_size : 3) + 1;
    for (int r = 0; r < lim; r++) begin
      for (int c = 0; c < lim; c++) begin
        RD_ROW = 5'(r);
        RD_COL = 5'(c);
        #1;
        ec = 0;
        eo = 0;
        if (r < m_size && c < m_size) begin
          ec = m_col[r][c];
          eo = int'(m_own[r][c]);
        end
        if (RD_COLOR !== 3'(ec) || RD_OWNED !== 1'(eo)) bad++;
      end
    end
    RD_ROW = 5'd31;
    RD_COL = 5'd31;
    #1;
    if (RD_COLOR !== 3'd0 || RD_OWNED !== 1'b0) bad++;
    RD_ROW = '0;
    RD_COL = '0;
    #1;
    chk(tag, bad, 0);
  endtask

  task automatic wait_ready(input string tag, input bit do_scan);
    int n = 0;
    while (BOARD_VALID !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, BOARD_VALID, 1);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_won"}, GAME_WON, (m_owned == m_size * m_size));
    chk({tag, "_owned"}, OWNED_COUNT, m_owned);
    chk({tag, "_moves"}, MOVE_COUNT, m_moves);
    if (do_scan) scan({tag, "_board"});
  endtask

  task automatic do_move(input int color, input bit do_scan);
    bit rej;
    rej = (color >= m_cn) || (color == m_col[0][0]);
    MOVE_VALID = 1'b1;
    MOVE_COLOR = 3'(color);
    tick();
    MOVE_VALID = 1'b0;
    chk("move_reject", MOVE_REJECT, rej);
    if (rej) begin
      chk("reject_valid", BOARD_VALID, 1);
      tick();
      chk("reject_pulse_end", MOVE_REJECT, 0);
      chk("reject_moves", MOVE_COUNT, m_moves);
    end else begin
      chk("move_busy", BUSY, 1);
      // A move strobe while busy must be dropped without a reject pulse.
      MOVE_VALID = 1'b1;
      MOVE_COLOR = 3'($urandom);
      tick();
      MOVE_VALID = 1'b0;
      chk("busy_move_ignored", MOVE_REJECT, 0);
      if (m_moves < 255) m_moves++;
      m_flood(color);
      wait_ready("move", do_scan);
    end
  endtask

  task automatic set_board_a();
    int a[9];
    a = '{0, 1, 1, 2, 1, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) m_col[i / 3][i % 3] = a[i];
  endtask

  initial begin
    // Power-on reset
    #2;
    chk("rst_busy", BUSY, 0);
    chk("rst_valid", BOARD_VALID, 0);
    chk("rst_won", GAME_WON, 0);
    chk("rst_reject", MOVE_REJECT, 0);
    chk("rst_moves", MOVE_COUNT, 0);
    chk("rst_owned", OWNED_COUNT, 0);
    chk("rst_rdcolor", RD_COLOR, 0);
    #10;
    RESET_N = 1'b1;
    tick();
    chk("idle_busy", BUSY, 0);

    // Restart while painting the 3x3 board
    set_board_a();
    start_load(3, 3);
    stream(0, 8, 1'b0);
    repeat (12) tick();
    chk("paint_busy", BUSY, 1);
    chk("paint_owned", OWNED_COUNT, 1);
    chk("paint_rdowned", RD_OWNED, 1);
    start_load(3, 3);
    chk("restart_busy", BUSY, 1);
    chk("restart_valid", BOARD_VALID, 0);
    chk("restart_owned", OWNED_COUNT, 0);
    chk("restart_moves", MOVE_COUNT, 0);
    chk("restart_rdowned", RD_OWNED, 0);

    // Load with gaps, then the directed game
    stream(0, 8, 1'b1);
    m_new_board();
    wait_ready("load_a", 1'b1);
    chk("load_a_owned1", OWNED_COUNT, 1);
    do_move(0, 1'b1);
    do_move(5, 1'b1);
    do_move(1, 1'b1);
    chk("move1_owned4", OWNED_COUNT, 4);
    chk("move1_rd00", RD_COLOR, 1);
    chk("move1_count", MOVE_COUNT, 1);
    do_move(0, 1'b1);
    chk("move2_owned8", OWNED_COUNT, 8);
    do_move(2, 1'b1);
    chk("move3_owned9", OWNED_COUNT, 9);
    chk("move3_won", GAME_WON, 1);
    chk("move3_count", MOVE_COUNT, 3);

    // Moves in WON are dropped silently
    MOVE_VALID = 1'b1;
    MOVE_COLOR = 3'd1;
    tick();
    MOVE_VALID = 1'b0;
    chk("won_no_reject", MOVE_REJECT, 0);
    tick();
    chk("won_hold", GAME_WON, 1);
    chk("won_moves", MOVE_COUNT, 3);

    // Moves during a load are dropped
    set_board_a();
    start_load(3, 3);
    MOVE_VALID = 1'b1;
    MOVE_COLOR = 3'd1;
    stream(0, 8, 1'b1);
    MOVE_VALID = 1'b0;
    chk("load_move_no_reject", MOVE_REJECT, 0);
    m_new_board();
    wait_ready("load_busy_move", 1'b1);

    // SIZE=31 clamps to 26, COLOR_NUM=15 clamps to 8
    for (int i = 0; i < 26; i++)
      for (int j = 0; j < 26; j++) m_col[i][j] = 0;
    m_col[25][25] = 1;
    start_load(31, 15);
    stream(0, 674, 1'b1);
    repeat (5) tick();
    chk("clamp_still_loading", BUSY, 1);
    chk("clamp_not_valid", BOARD_VALID, 0);
    stream(675, 675, 1'b0);
    m_new_board();
    wait_ready("clamp", 1'b1);
    chk("clamp_owned675", OWNED_COUNT, 675);
    do_move(7, 1'b0);
    do_move(1, 1'b1);
    chk("clamp_won", GAME_WON, 1);
    chk("clamp_owned676", OWNED_COUNT, 676);

    // Move counter saturation on a board that cannot be won by alternating 2/0
    m_col[0][0] = 0;
    m_col[0][1] = 1;
    m_col[1][0] = 1;
    m_col[1][1] = 1;
    start_load(2, 3);
    stream(0, 3, 1'b0);
    m_new_board();
    wait_ready("sat_load", 1'b1);
    for (int i = 0; i < 256; i++) do_move(((i % 2) == 0) ? 2 : 0, 1'b0);
    chk("sat_count", MOVE_COUNT, 255);
    do_move(1, 1'b1);
    chk("sat_won", GAME_WON, 1);
    chk("sat_count_after", MOVE_COUNT, 255);

    // Random games against the model
    for (int g = 0; g < 4; g++) begin
      start_load(int'($urandom_range(0, 7)), int'($urandom_range(0, 10)));
      for (int i = 0; i < m_size; i++)
        for (int j = 0; j < m_size; j++) m_col[i][j] = int'($urandom_range(0, m_cn - 1));
      stream(0, m_size * m_size - 1, 1'b1);
      m_new_board();
      wait_ready("rand_load", 1'b1);
      for (int mv = 0; mv < 20; mv++) begin
        if (m_owned == m_size * m_size) break;
        do_move(int'($urandom_range(0, 7)), 1'b1);
      end
    end

    // Asynchronous reset in the middle of a sweep
    set_board_a();
    start_load(3, 3);
    stream(0, 8, 1'b0);
    repeat (3) tick();
    chk("pre_reset_busy", BUSY, 1);
    RESET_N = 1'b0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_valid", BOARD_VALID, 0);
    chk("arst_owned", OWNED_COUNT, 0);
    chk("arst_moves", MOVE_COUNT, 0);
    chk("arst_won", GAME_WON, 0);
    chk("arst_reject", MOVE_REJECT, 0);
    chk("arst_rdowned", RD_OWNED, 0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    m_size = 0;
    m_clear_own();
    tick();
    chk("arst_idle", BUSY, 0);
    scan("arst_board");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/flood_engine.md
Name: flood_engine

Overview:
- Game-state core directly downstream of the board generator.
- Accepts the generated board as a raster cell stream and holds colour plus "owned" (flooded) flag per cell.
- Applies player colour moves by iterative flood relaxation from cell (0,0), counts moves and detects a win.
- Offers a combinational read port for the display stage.

Parameters:
MAX_SIZE, 26, maximum board edge; storage is MAX_SIZE x MAX_SIZE
COLOR_W, 3, bits per cell colour
MOVE_W, 8, move counter width (saturates at all-ones)

Ports:
CLOCK  input  1  system clock; all state changes on posedge
RESET_N  input  1  asynchronous active-low reset
LOAD_START  input  1  pulse; latch SIZE/COLOR_NUM and begin a board load
SIZE  input  5  board edge, sampled at LOAD_START; clamped to 2..MAX_SIZE
COLOR_NUM  input  4  colours in play, sampled at LOAD_START; clamped to 3..8
LOAD_VALID  input  1  LOAD_COLOR valid this cycle
LOAD_COLOR  input  COLOR_W  next cell colour, raster order (row-major from (0,0))
MOVE_VALID  input  1  player move strobe
MOVE_COLOR  input  COLOR_W  requested flood colour
RD_ROW  input  5  display read row
RD_COL  input  5  display read column
RD_COLOR  output  COLOR_W  colour at (RD_ROW,RD_COL), combinational; 0 if out of range
RD_OWNED  output  1  owned flag at read address, combinational; 0 if out of range
BUSY  output  1  high in LOAD, SWEEP, PAINT
BOARD_VALID  output  1  high in READY or WON
MOVE_REJECT  output  1  one-cycle pulse on an ignored move in READY
GAME_WON  output  1  high in WON
MOVE_COUNT  output  MOVE_W  accepted moves since last load
OWNED_COUNT  output  10  number of owned cells

Behaviour:
- Reset (async, RESET_N=0):
  - State IDLE; all colours and owned flags 0.
  - All outputs 0; internal counters 0.
- States: IDLE, LOAD, SWEEP, PAINT, READY, WON.
- LOAD_START (any state, including mid-SWEEP/PAINT; has priority over all other inputs):
  - Latch clamped SIZE/COLOR_NUM.
  - Clear all owned flags, MOVE_COUNT, OWNED_COUNT; reset the load pointer; go to LOAD.
- LOAD:
  - Each LOAD_VALID cycle writes LOAD_COLOR to the pointer cell and advances it (column wraps at SIZE-1 into the next row).
  - Cycles without LOAD_VALID hold the pointer.
  - The cycle after the write of cell (SIZE-1,SIZE-1):
    - set owned(0,0);
    - OWNED_COUNT=1;
    - target = colour(0,0);
    - go to SWEEP.
  - This initial flood is not a move.
- SWEEP:
  - Raster scan, one cell per cycle, over the SIZE x SIZE region only.
  - A cell becomes owned when all three hold:
    - it is not owned;
    - its colour == target;
    - at least one in-bounds 4-neighbour is owned.
  - On each new ownership: OWNED_COUNT+1 and set the pass-changed flag.
  - Flags set earlier in a pass are visible later in the same pass.
  - End of pass: if changed, clear the flag and start a new pass at (0,0); else go to PAINT.
  - Each pass takes SIZE*SIZE cycles; at least one pass per move.
- PAINT:
  - Raster scan, one cell per cycle; owned cells get colour := target.
  - End of scan: go to WON if OWNED_COUNT == SIZE*SIZE, else READY.
- READY, on MOVE_VALID:
  - Reject if MOVE_COLOR >= latched COLOR_NUM, or MOVE_COLOR == colour(0,0). A reject pulses MOVE_REJECT for one cycle and changes no other state.
  - Otherwise: MOVE_COUNT+1 (saturating), target = MOVE_COLOR, go to SWEEP.
- MOVE_VALID outside READY: ignored silently; no reject pulse.
- WON: holds until LOAD_START or reset.
- MOVE_COUNT at all-ones: stays there; the move is still applied.
- RD_* during BUSY: return live storage; partial values are permitted.

Test Plan:
- Reset: assert RESET_N=0 mid-SWEEP -> state IDLE immediately; all outputs 0; RD_COLOR=0 everywhere after release.
- Load, 3x3, COLOR_NUM=3, stream 0,1,1,2,1,0,0,0,0 -> after sweep/paint: BOARD_VALID=1, OWNED_COUNT=1, MOVE_COUNT=0.
- First move on the same board: MOVE_COLOR=1 -> owned {(0,0),(0,1),(0,2),(1,1)}; OWNED_COUNT=4; RD_COLOR(0,0)=1; MOVE_COUNT=1.
- Win sequence: then MOVE_COLOR=0 -> OWNED_COUNT=8; then MOVE_COLOR=2 -> OWNED_COUNT=9, GAME_WON=1, MOVE_COUNT=3.
- Rejects and ignored moves:
  - In READY, MOVE_COLOR equal to colour(0,0) -> MOVE_REJECT pulse, MOVE_COUNT unchanged.
  - In READY, MOVE_COLOR=5 with COLOR_NUM=3 -> same response.
  - MOVE_VALID while BUSY -> no effect.
- Restart and clamping:
  - LOAD_START during PAINT -> counts cleared, LOAD entered next cycle.
  - LOAD_VALID gaps tolerated.
  - SIZE=31 clamps to 26: the load needs exactly 676 valid cells.
